variance_stream: RTL and testbench
==================================

VARIANCE_STREAM -- requirements
Module: variance_stream

Interface
REQ-001 SHALL have parameter N, default 4, meaning samples per window; power of two, N >= 2.
REQ-002 SHALL have parameter DW, default 16, meaning signed sample and result width.
REQ-003 SHALL have parameter FRAC, default 8, meaning fractional bits (Q(DW-FRAC).FRAC).
REQ-004 SHALL have port clk  input  1  meaning sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  meaning asynchronous active-low reset.
REQ-006 SHALL have port clr  input  1  meaning synchronous abort of the current window.
REQ-007 SHALL have port in_valid  input  1  meaning in_data is valid.
REQ-008 SHALL have port in_ready  output  1  meaning the block accepts a sample.
REQ-009 SHALL have port in_data  input  DW  meaning signed sample.
REQ-010 SHALL have port out_valid  output  1  meaning mean and variance are valid.
REQ-011 SHALL have port out_ready  input  1  meaning the consumer accepts the result.
REQ-012 SHALL have port mean  output  DW  meaning signed window mean, same Q format as input.
REQ-013 SHALL have port variance  output  DW  meaning signed population variance, same Q format, never negative.

Function
REQ-014 SHALL implement states LOAD, MEAN, ACC and OUT; in_ready=1 only in LOAD and out_valid=1 only in OUT.
REQ-015 LOAD: on in_valid&&in_ready, SHALL store in_data in buf[cnt], add sign-extended in_data to sum, and increment cnt; the Nth accept SHALL move to MEAN with cnt=0.
REQ-016 sum SHALL be DW+log2(N) bits signed and SHALL never overflow.
REQ-017 MEAN (1 cycle): SHALL register mean = sum >>> log2(N), arithmetic shift (floor), low DW bits; then move to ACC.
REQ-018 ACC (N cycles, i=0..N-1): SHALL form diff = buf[i]-mean at DW+1 bits, sq = diff*diff, and acc += sq.
REQ-019 acc SHALL be 2*DW+2+log2(N) bits and SHALL be cleared on entry to ACC; after i=N-1 the block SHALL move to OUT.
REQ-020 variance SHALL equal (acc >> (log2(N)+FRAC)), saturated to 2^(DW-1)-1 when larger, computed on entry to OUT.
REQ-021 Latency: if the final sample handshake occurs in cycle c, out_valid SHALL be high from cycle c+N+2.
REQ-022 OUT: mean and variance SHALL be held stable while out_valid&&!out_ready.
REQ-023 OUT: out_valid&&out_ready SHALL return the block to LOAD with cnt=0 and sum=0, and in_ready=1 in the next cycle.
REQ-024 in_ready SHALL not depend combinationally on out_ready or in_valid.
REQ-025 clr SHALL return the block to LOAD from any state with cnt=0, sum=0, out_valid=0; mean and variance SHALL hold their last values.
REQ-026 clr SHALL take priority over a simultaneous input or output handshake; that sample or result SHALL be dropped.
REQ-027 in_valid outside LOAD SHALL be ignored; in_data SHALL not be sampled.

Reset
REQ-028 rst_n low SHALL asynchronously force state=LOAD, cnt=0, sum=0, acc=0, mean=0, variance=0, out_valid=0, in_ready=0.
REQ-029 in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-030 Reset asserted mid-window SHALL discard all partial data; buf contents need not be cleared.

Verification (N=4, DW=16, FRAC=8)
REQ-031 Basic: 0x0100, 0x0200, 0x0300, 0x0400 back-to-back -> mean=0x0280, variance=0x0140, out_valid in cycle c+6.
REQ-032 Constant: four samples of 0xFF00 (-1.0) -> mean=0xFF00, variance=0x0000.
REQ-033 Saturation: 0x8000, 0x7FFF, 0x8000, 0x7FFF -> mean=0xFFFF, variance=0x7FFF.
REQ-034 Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 -> outputs stable, in_ready=0, no samples consumed.
REQ-035 Abort: clr pulsed in ACC, then 0x0100..0x0400 sent -> result equals REQ-031 with no contamination from the aborted window.
REQ-036 Reset: rst_n low after the 2nd sample -> all outputs 0 immediately; a subsequent full window gives correct results.

Source files
------------

// File: rtl/variance_stream.sv
// variance_stream: collects N signed fixed-point samples per window, then
// reports the floor mean and the population variance of that window.
// Flow: LOAD (gather N samples) -> MEAN (1 cycle) -> ACC (N cycles) -> OUT.
module variance_stream #(
   parameter int N    = 4,
   parameter int DW   = 16,
   parameter int FRAC = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] mean,
   output logic [DW-1:0] variance
);

   localparam int LOG2N = $clog2(N);
   localparam int SW    = DW + LOG2N;           // running sum width
   localparam int DFW   = DW + 1;               // deviation width
   localparam int SQW   = 2 * DW + 2;           // squared deviation width
   localparam int ACCW  = 2 * DW + 2 + LOG2N;   // sum of squares width
   localparam int SHIFT = LOG2N + FRAC;         // divide by N, drop one FRAC

   localparam logic [LOG2N-1:0] CNT_ZERO = {LOG2N{1'b0}};
   localparam logic [LOG2N-1:0] CNT_ONE  = LOG2N'(1);
   localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N - 1);
   localparam logic [ACCW-1:0]  VAR_MAX  = {{(ACCW - DW + 1){1'b0}}, {(DW - 1){1'b1}}};

   typedef enum logic [1:0] {
      S_LOAD = 2'd0,
      S_MEAN = 2'd1,
      S_ACC  = 2'd2,
      S_OUT  = 2'd3
   } state_t;

   // Scales the sum of squares down to the sample Q format and clamps it
   // to the largest positive result value.
   function automatic logic [DW-1:0] sat_var(input logic [ACCW-1:0] a);
      logic [ACCW-1:0] sh;
      sh = a >> SHIFT;
      if (sh > VAR_MAX) begin
         sat_var = VAR_MAX[DW-1:0];
      end else begin
         sat_var = sh[DW-1:0];
      end
   endfunction

   state_t                  state_q, state_d;
   logic [LOG2N-1:0]        cnt_q, cnt_d;
   logic signed [SW-1:0]    sum_q, sum_d;
   logic [ACCW-1:0]         acc_q, acc_d;
   logic [DW-1:0]           mean_q, mean_d;
   logic [DW-1:0]           var_q, var_d;
   logic                    in_ready_q;
   logic                    out_valid_q;
   logic [DW-1:0]           samp_q [N];

   logic                    samp_we_s;
   logic signed [SW-1:0]    sum_ext_s;
   logic signed [DFW-1:0]   diff_s;
   logic signed [SQW-1:0]   diff_x_s;
   logic signed [SQW-1:0]   sq_s;
   logic [ACCW-1:0]         acc_add_s;

   // Datapath helpers: sign-extended sample, deviation of buffered sample
   // cnt from the registered mean, its square and the updated sum of squares.
   always_comb begin
      sum_ext_s = {{LOG2N{in_data[DW-1]}}, in_data};
      diff_s    = $signed({samp_q[cnt_q][DW-1], samp_q[cnt_q]})
                - $signed({mean_q[DW-1], mean_q});
      diff_x_s  = SQW'(diff_s);
      sq_s      = diff_x_s * diff_x_s;
      acc_add_s = acc_q + {{LOG2N{1'b0}}, sq_s};
   end

   // Next-state and datapath control; clr overrides every handshake.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sum_d     = sum_q;
      acc_d     = acc_q;
      mean_d    = mean_q;
      var_d     = var_q;
      samp_we_s = 1'b0;
      if (clr) begin
         state_d = S_LOAD;
         cnt_d   = CNT_ZERO;
         sum_d   = {SW{1'b0}};
      end else begin
         case (state_q)
            S_LOAD: begin
               if (in_valid && in_ready_q) begin
                  samp_we_s = 1'b1;
                  sum_d     = sum_q + sum_ext_s;
                  if (cnt_q == CNT_LAST) begin
                     cnt_d   = CNT_ZERO;
                     state_d = S_MEAN;
                  end else begin
                     cnt_d = cnt_q + CNT_ONE;
                  end
               end else begin
                  samp_we_s = 1'b0;
               end
            end
            S_MEAN: begin
               // floor division by N through an arithmetic shift
               mean_d  = DW'(sum_q >>> LOG2N);
               acc_d   = {ACCW{1'b0}};
               state_d = S_ACC;
            end
            S_ACC: begin
               acc_d = acc_add_s;
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = CNT_ZERO;
                  var_d   = sat_var(acc_add_s);
                  state_d = S_OUT;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            S_OUT: begin
               if (out_valid_q && out_ready) begin
                  state_d = S_LOAD;
                  cnt_d   = CNT_ZERO;
                  sum_d   = {SW{1'b0}};
               end else begin
                  state_d = S_OUT;
               end
            end
            default: begin
               state_d = S_LOAD;
               cnt_d   = CNT_ZERO;
               sum_d   = {SW{1'b0}};
            end
         endcase
      end
   end

   // Control and result registers; handshake flags are registered so that
   // in_ready never follows in_valid or out_ready combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_LOAD;
         cnt_q       <= CNT_ZERO;
         sum_q       <= {SW{1'b0}};
         acc_q       <= {ACCW{1'b0}};
         mean_q      <= {DW{1'b0}};
         var_q       <= {DW{1'b0}};
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sum_q       <= sum_d;
         acc_q       <= acc_d;
         mean_q      <= mean_d;
         var_q       <= var_d;
         in_ready_q  <= (state_d == S_LOAD);
         out_valid_q <= (state_d == S_OUT);
      end
   end

   // Sample buffer; stale contents are harmless because every window
   // overwrites all N entries before they are read.
   always_ff @(posedge clk) begin
      if (samp_we_s) begin
         samp_q[cnt_q] <= in_data;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign mean      = mean_q;
   assign variance  = var_q;

endmodule

// File: tb/tb_variance_stream.sv
// Directed testbench for variance_stream (N=4, DW=16, FRAC=8).
module tb_variance_stream;

   localparam int N = 4;

   logic        clk;
   logic        rst_n;
   logic        clr;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] mean;
   logic [15:0] variance;

   int n_vec;
   int n_err;

   typedef struct {
      logic [15:0] s0, s1, s2, s3;
      logic [15:0] m, v;
   } vec_t;

   vec_t tbl [7];

   variance_stream #(.N(4), .DW(16), .FRAC(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .mean     (mean),
      .variance (variance)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_vec(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d,
                          input logic [15:0] m, input logic [15:0] v);
      tbl[i].s0 = a; tbl[i].s1 = b; tbl[i].s2 = c; tbl[i].s3 = d;
      tbl[i].m  = m; tbl[i].v  = v;
   endtask

   // Offer one sample and return just after the edge that accepted it.
   task automatic send_sample(input logic [15:0] d);
      int w;
      w = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && w < 20) begin
         step();
         w++;
      end
      if (w >= 20) begin
         n_vec++;
         n_err++;
         $display("FAIL accept_timeout: in_ready low for %0d cycles, expected high", w);
      end
      step();
      in_valid = 1'b0;
   endtask

   // Last handshake in cycle c; out_valid must first show in cycle c+N+2,
   // i.e. N+1 edges after the accepting edge.
   task automatic wait_result(input string name);
      int lat;
      lat = 0;
      while (!out_valid && lat < 40) begin
         step();
         lat++;
      end
      chk({name, "_latency"}, lat, N + 1);
   endtask

   task automatic consume();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("in_ready_after_out", {31'd0, in_ready}, 32'd1);
      chk("out_valid_after_out", {31'd0, out_valid}, 32'd0);
   endtask

   task automatic run_window(input string name, input vec_t v);
      send_sample(v.s0);
      send_sample(v.s1);
      send_sample(v.s2);
      send_sample(v.s3);
      wait_result(name);
      chk({name, "_mean"}, {16'd0, mean}, {16'd0, v.m});
      chk({name, "_var"}, {16'd0, variance}, {16'd0, v.v});
      consume();
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      clr       = 1'b0;
      in_valid  = 1'b0;
      in_data   = 16'h0000;
      out_ready = 1'b0;

      set_vec(0, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0280, 16'h0140); // basic
      set_vec(1, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 16'h0000); // constant -1.0
      set_vec(2, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000); // zeros
      set_vec(3, 16'h0000, 16'h0000, 16'h0000, 16'h0400, 16'h0100, 16'h0300); // mean 1, var 3
      set_vec(4, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000); // floor of -1/4
      set_vec(5, 16'h0200, 16'hFE00, 16'h0200, 16'hFE00, 16'h0000, 16'h0400); // +-2 -> var 4
      set_vec(6, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h7FFF); // saturation

      // Reset state
      step();
      step();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_mean", {16'd0, mean}, 32'd0);
      chk("rst_var", {16'd0, variance}, 32'd0);
      #2 rst_n = 1'b1;
      #1 chk("in_ready_before_edge", {31'd0, in_ready}, 32'd0);
      step();
      chk("in_ready_first_edge", {31'd0, in_ready}, 32'd1);

      // Table-driven windows
      for (int i = 0; i < 7; i++) begin
         run_window($sformatf("vec%0d", i), tbl[i]);
      end

      // Backpressure: result held, no samples taken while out_ready is low
      send_sample(16'h0100);
      send_sample(16'h0200);
      send_sample(16'h0300);
      send_sample(16'h0400);
      wait_result("bp");
      for (int k = 0; k < 10; k++) begin
         in_valid = 1'b1;
         in_data  = 16'h7777;
         step();
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_mean", {16'd0, mean}, 32'h0280);
         chk("bp_var", {16'd0, variance}, 32'h0140);
      end
      in_valid = 1'b0;
      consume();
      run_window("after_bp", tbl[3]);

      // clr beats a simultaneous input handshake: that sample is dropped
      in_valid = 1'b1;
      in_data  = 16'h7F00;
      clr      = 1'b1;
      step();
      clr      = 1'b0;
      in_valid = 1'b0;
      chk("clr_load_in_ready", {31'd0, in_ready}, 32'd1);
      run_window("after_clr_load", tbl[0]);

      // Abort in ACC: mean already updated for the aborted window, variance held
      send_sample(16'h1000);
      send_sample(16'h1000);
      send_sample(16'h1000);
      send_sample(16'h1000);
      step();
      step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
      chk("abort_mean_hold", {16'd0, mean}, 32'h1000);
      chk("abort_var_hold", {16'd0, variance}, 32'h0140);
      for (int k = 0; k < 8; k++) step();
      chk("abort_no_result", {31'd0, out_valid}, 32'd0);
      run_window("after_abort", tbl[0]);

      // clr beats a simultaneous output handshake: result dropped, values held
      send_sample(16'h0200);
      send_sample(16'hFE00);
      send_sample(16'h0200);
      send_sample(16'hFE00);
      wait_result("clr_out");
      clr       = 1'b1;
      out_ready = 1'b1;
      step();
      clr       = 1'b0;
      out_ready = 1'b0;
      chk("clr_out_valid", {31'd0, out_valid}, 32'd0);
      chk("clr_out_mean", {16'd0, mean}, 32'h0000);
      chk("clr_out_var", {16'd0, variance}, 32'h0400);
      run_window("after_clr_out", tbl[0]);

      // Asynchronous reset after the 2nd sample of a window
      send_sample(16'h0500);
      send_sample(16'h0600);
      rst_n = 1'b0;
      #1;
      chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_mean", {16'd0, mean}, 32'd0);
      chk("arst_var", {16'd0, variance}, 32'd0);
      #2 rst_n = 1'b1;
      step();
      chk("arst_in_ready_rise", {31'd0, in_ready}, 32'd1);
      run_window("after_arst", tbl[3]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
